// File: rtl/rect_fill_engine.sv
// rect_fill_engine: clips a rectangle fill command to the screen and streams its pixels in raster order
module rect_fill_engine #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int COLOR_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [9:0]             i_x0,
  input  logic [9:0]             i_y0,
  input  logic [9:0]             i_x1,
  input  logic [9:0]             i_y1,
  input  logic [COLOR_WIDTH-1:0] i_color,
  output logic                   o_pixel_we,
  output logic [9:0]             o_pixel_x,
  output logic [9:0]             o_pixel_y,
  output logic [COLOR_WIDTH-1:0] o_pixel_color,
  input  logic                   i_pixel_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [$clog2(SCREEN_WIDTH*SCREEN_HEIGHT+1)-1:0] o_pixel_count
);
  localparam int CW = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT+1);
  localparam logic [9:0] XM = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0] YM = 10'(SCREEN_HEIGHT - 1);
  typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;
  state_t state, state_n;
  logic [9:0] xmin, xmax, ymin, ymax, cur_x, cur_y;
  logic [COLOR_WIDTH-1:0] color;
  logic [CW-1:0] cnt, pixel_count;
  logic last, empty;
  assign last  = cur_x == xmax && cur_y == ymax;
  assign empty = xmin > XM || ymin > YM;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = i_cmd_valid ? CLIP : IDLE;
      CLIP:    state_n = empty ? DONE : FILL;
      FILL:    state_n = (i_pixel_ready && last) ? DONE : FILL;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      xmin        <= '0;
      xmax        <= '0;
      ymin        <= '0;
      ymax        <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      color       <= '0;
      cnt         <= '0;
      pixel_count <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (i_cmd_valid) begin
          xmin  <= i_x0 < i_x1 ? i_x0 : i_x1;
          xmax  <= i_x0 < i_x1 ? i_x1 : i_x0;
          ymin  <= i_y0 < i_y1 ? i_y0 : i_y1;
          ymax  <= i_y0 < i_y1 ? i_y1 : i_y0;
          color <= i_color;
          cnt   <= '0;
        end
        CLIP: begin
          xmax  <= xmax > XM ? XM : xmax;
          ymax  <= ymax > YM ? YM : ymax;
          cur_x <= xmin;
          cur_y <= ymin;
          if (empty) pixel_count <= '0;
        end
        FILL: if (i_pixel_ready) begin
          // count is published on the final beat so it is valid alongside o_done
          cnt   <= cnt + 1'b1;
          cur_x <= cur_x < xmax ? cur_x + 10'd1 : xmin;
          cur_y <= cur_x < xmax ? cur_y : cur_y + 10'd1;
          if (last) pixel_count <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign o_cmd_ready   = state == IDLE;
  assign o_busy        = state != IDLE;
  assign o_pixel_we    = state == FILL;
  assign o_done        = state == DONE;
  assign o_pixel_x     = cur_x;
  assign o_pixel_y     = cur_y;
  assign o_pixel_color = color;
  assign o_pixel_count = pixel_count;
endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
- Upstream pixel-write generator that feeds the framebuffer write port.
- Accepts one axis-aligned rectangle fill command (two corners plus a colour) through a valid/ready handshake.
- Clips the rectangle to the screen and emits one pixel write per covered pixel, in raster order, with back-pressure from the consumer.
- Used for screen clears, background fills and debug overlays.

Parameters:
- SCREEN_WIDTH, 640, screen width in pixels; x coordinates are valid from 0 to SCREEN_WIDTH-1.
- SCREEN_HEIGHT, 480, screen height in pixels; y coordinates are valid from 0 to SCREEN_HEIGHT-1.
- COLOR_WIDTH, 32, pixel colour width in bits.

Ports:
- clk  input  1  clock; all logic is on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- i_cmd_valid  input  1  a command is presented.
- o_cmd_ready  output  1  engine can accept a command; high only in IDLE.
- i_x0  input  10  corner A, x.
- i_y0  input  10  corner A, y.
- i_x1  input  10  corner B, x.
- i_y1  input  10  corner B, y.
- i_color  input  COLOR_WIDTH  fill colour.
- o_pixel_we  output  1  pixel write valid.
- o_pixel_x  output  10  pixel x.
- o_pixel_y  output  10  pixel y.
- o_pixel_color  output  COLOR_WIDTH  pixel colour.
- i_pixel_ready  input  1  consumer accepts the current pixel this cycle.
- o_busy  output  1  command in progress (any state other than IDLE).
- o_done  output  1  one-cycle pulse when a command completes.
- o_pixel_count  output  $clog2(SCREEN_WIDTH*SCREEN_HEIGHT+1)  number of pixels written by the last command.

Behaviour:
- Reset values (next edge with rst=1): state IDLE; o_pixel_we=0; o_done=0; o_busy=0; o_pixel_count=0; o_pixel_x, o_pixel_y and o_pixel_color all 0.
- Reset mid-command aborts the command: no o_done pulse and no further writes.
- State IDLE:
  - o_cmd_ready=1.
  - When i_cmd_valid=1, the command is accepted. Latch xmin=min(x0,x1), xmax=max(x0,x1), ymin=min(y0,y1), ymax=max(y0,y1) and the colour.
  - Clear the pixel counter, then go to CLIP.
- State CLIP (exactly one cycle):
  - If xmin>SCREEN_WIDTH-1 or ymin>SCREEN_HEIGHT-1, the fill is empty: go to DONE.
  - Otherwise clamp xmax to SCREEN_WIDTH-1 and ymax to SCREEN_HEIGHT-1, load cur_x=xmin and cur_y=ymin, and go to FILL.
- State FILL:
  - o_pixel_we=1, o_pixel_x=cur_x, o_pixel_y=cur_y, o_pixel_color=latched colour.
  - A beat is accepted on a cycle where o_pixel_we and i_pixel_ready are both 1.
  - On each accepted beat the counter increments and the position advances:
    - if cur_x<xmax, cur_x increments;
    - otherwise cur_x returns to xmin and cur_y increments;
    - if cur_x==xmax and cur_y==ymax (last pixel), go to DONE.
  - While i_pixel_ready=0, x, y, colour and we hold stable.
  - o_pixel_we drops on the cycle after the last accepted beat.
- State DONE:
  - o_done=1 for one cycle, o_pixel_count is updated, o_busy stays 1, o_pixel_we=0.
  - Next state is IDLE; a new command can be accepted on the following cycle.
- Timing, with command accepted at edge N:
  - CLIP runs in cycle N+1.
  - The first o_pixel_we is seen in cycle N+2.
  - With i_pixel_ready held at 1, P pixels occupy cycles N+2 to N+1+P, and o_done is seen in cycle N+2+P.
  - An empty fill gives o_done in cycle N+2.
- i_cmd_valid while the engine is busy is ignored; o_cmd_ready=0 in that case.
- Coordinate arithmetic is 10-bit unsigned and never wraps, because comparisons against xmax are made before incrementing.
- Raster order: x fastest, ascending x then ascending y, regardless of the corner order given.

Test Plan:
- Single pixel: (5,7)-(5,7), colour 0xDEADBEEF, ready=1 -> one write at x=5, y=7 with that colour in cycle N+2; o_done in N+3; o_pixel_count=1.
- Swapped corners: (11,21)-(10,20) -> writes in order (10,20), (11,20), (10,21), (11,21); count=4; o_done in N+6.
- Clipping: (636,478)-(1023,1023) -> writes cover x 636..639 and y 478..479; 8 writes; last write at (639,479); count=8.
- Fully off-screen: (700,10)-(800,20) -> no o_pixel_we; o_done in N+2; count=0; o_cmd_ready high again in N+3.
- Back-pressure: 3x1 fill at (0,0), ready held low for 3 cycles while pixel (1,0) is presented -> x=1, y=0 and we held stable through the stall; no pixel duplicated or skipped; count=3.
- Reset mid-fill: full-screen fill, rst asserted after 100 accepted beats -> o_pixel_we=0 and o_busy=0 the next cycle; no o_done; o_cmd_ready=1.
